sprite_frame_ram: RTL

- Parametrised palette-index sprite store replacing the per-sprite fixed-depth frame RAMs; holds NUM_FRAMES frames of SPRITE_W x SPRITE_H pixels.
- Serves NUM_RD independent (frame, x, y) read channels to the pixel pipeline, with 2-cycle registered latency and a transparency flag.
- One host write port, plus an internal fill engine that clears or paints a whole frame (one pixel per cycle).
- Sits between the sprite/draw logic and the palette lookup.

---
 rtl/sprite_ram_pkg.sv | 24 ++
 rtl/sprite_frame_ram_if.sv | 64 ++++++
 rtl/sprite_rd_chan.sv | 78 +++++++
 rtl/sprite_frame_ram.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sprite_ram_pkg.sv
// Shared types, defaults and addressing helpers for the sprite_frame_ram block.
package sprite_ram_pkg;

  localparam int DEF_DATA_W          = 5;
  localparam int DEF_TRANSPARENT_IDX = 0;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  // Linear pixel address of (frame, x, y). Evaluated at 32 bits so that no term is truncated.
  function automatic int unsigned sprite_addr(input int unsigned frame, input int unsigned x,
                                              input int unsigned y, input int unsigned sprite_w,
                                              input int unsigned sprite_h);
    return frame * sprite_w * sprite_h + y * sprite_w + x;
  endfunction

  function automatic logic below(input int unsigned value, input int unsigned limit);
    return value < limit;
  endfunction

endpackage

// File: rtl/sprite_frame_ram_if.sv
// Pixel-pipeline read channels, host write port and fill control of sprite_frame_ram.
// rd_mirror exists only when SPRITE_RAM_MIRROR_EN is defined.
interface sprite_frame_ram_if
  import sprite_ram_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SPRITE_W   = 28,
  parameter int SPRITE_H   = 28,
  parameter int NUM_FRAMES = 4,
  parameter int NUM_RD     = 2
);
  localparam int DEPTH   = NUM_FRAMES * SPRITE_W * SPRITE_H;
  localparam int FRAME_W = $clog2(NUM_FRAMES);
  localparam int X_W     = $clog2(SPRITE_W);
  localparam int Y_W     = $clog2(SPRITE_H);
  localparam int ADDR_W  = $clog2(DEPTH);

  logic [NUM_RD-1:0]         rd_req;
  logic [NUM_RD*FRAME_W-1:0] rd_frame;
  logic [NUM_RD*X_W-1:0]     rd_x;
  logic [NUM_RD*Y_W-1:0]     rd_y;
`ifdef SPRITE_RAM_MIRROR_EN
  logic [NUM_RD-1:0]         rd_mirror;
`endif
  logic [NUM_RD-1:0]         rd_valid;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]         rd_transp;

  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_ready;

  logic                      fill_start;
  logic [FRAME_W-1:0]        fill_frame;
  logic [DATA_W-1:0]         fill_value;
  logic                      fill_busy;
  logic                      fill_done;

  modport master (
`ifdef SPRITE_RAM_MIRROR_EN
    output rd_mirror,
`endif
    output rd_req, rd_frame, rd_x, rd_y,
    input  rd_valid, rd_data, rd_transp,
    output wr_en, wr_addr, wr_data,
    input  wr_ready,
    output fill_start, fill_frame, fill_value,
    input  fill_busy, fill_done
  );

  modport slave (
`ifdef SPRITE_RAM_MIRROR_EN
    input  rd_mirror,
`endif
    input  rd_req, rd_frame, rd_x, rd_y,
    output rd_valid, rd_data, rd_transp,
    input  wr_en, wr_addr, wr_data,
    output wr_ready,
    input  fill_start, fill_frame, fill_value,
    output fill_busy, fill_done
  );

endinterface

// File: rtl/sprite_rd_chan.sv
// One read channel: address/range check, memory sample, registered response two cycles later.
// With SPRITE_RAM_MIRROR_EN defined, the mirror input flips the column horizontally.
module sprite_rd_chan
  import sprite_ram_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int SPRITE_W        = 28,
  parameter int SPRITE_H        = 28,
  parameter int NUM_FRAMES      = 4,
  parameter int TRANSPARENT_IDX = DEF_TRANSPARENT_IDX,
  parameter int ADDR_W          = 12,
  parameter int FRAME_W         = 2,
  parameter int X_W             = 5,
  parameter int Y_W             = 5
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               req,
  input  logic [FRAME_W-1:0] frame,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
`ifdef SPRITE_RAM_MIRROR_EN
  input  logic               mirror,
`endif
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               valid,
  output logic [DATA_W-1:0]  data,
  output logic               transp
);

  localparam logic [DATA_W-1:0] TRANSP = DATA_W'(TRANSPARENT_IDX);

  logic              in_range;
  logic [31:0]       col;
  logic              s1_valid;
  logic              s1_in_range;
  logic [DATA_W-1:0] s1_data;

  // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    in_range = below(32'(frame), NUM_FRAMES) && below(32'(x), SPRITE_W) &&
               below(32'(y), SPRITE_H);
`ifdef SPRITE_RAM_MIRROR_EN
    col      = mirror ? 32'(SPRITE_W - 1) - 32'(x) : 32'(x);
`else
    col      = 32'(x);
`endif
    // Out-of-range requests park the address at 0; the sampled word is discarded below.
    mem_addr = in_range ? ADDR_W'(sprite_addr(32'(frame), col, 32'(y), SPRITE_W, SPRITE_H))
                        : '0;
  end

  // NOTE: non-blocking assignments keep both pipeline stages sampling pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      s1_data     <= '0;
      valid       <= 1'b0;
      data        <= '0;
      transp      <= 1'b0;
    end else begin
      // The array is sampled at the request edge, so a same-cycle write is seen read-first.
      s1_valid <= req;
      if (req) begin
        s1_in_range <= in_range;
        s1_data     <= in_range ? mem_rdata : TRANSP;
      end
      valid <= s1_valid;
      if (s1_valid) begin
        data   <= s1_data;
        transp <= !s1_in_range || (s1_data == TRANSP);
      end
    end
  end

endmodule

// File: rtl/sprite_frame_ram.sv
// Multi-frame palette-index sprite store: NUM_RD pipelined read channels, one host write port
// and a whole-frame fill engine. Define SPRITE_RAM_MIRROR_EN for per-channel horizontal flip.
module sprite_frame_ram
  import sprite_ram_pkg::*;
#(
  parameter int    DATA_W          = DEF_DATA_W,
  parameter int    SPRITE_W        = 28,
  parameter int    SPRITE_H        = 28,
  parameter int    NUM_FRAMES      = 4,
  parameter int    NUM_RD          = 2,
  parameter int    TRANSPARENT_IDX = DEF_TRANSPARENT_IDX,
  parameter string INIT_FILE       = "sprite_bytes/frogger.txt"
) (
  input logic               Clk,
  input logic               Reset_n,
  sprite_frame_ram_if.slave bus
);

  localparam int FRAME_PIX = SPRITE_W * SPRITE_H;
  localparam int DEPTH     = NUM_FRAMES * FRAME_PIX;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int FRAME_W   = $clog2(NUM_FRAMES);
  localparam int X_W       = $clog2(SPRITE_W);
  localparam int Y_W       = $clog2(SPRITE_H);
  localparam int PIX_W     = $clog2(FRAME_PIX);

  logic [DATA_W-1:0] mem [DEPTH];

  fill_state_t       state_q, state_d;
  logic [PIX_W-1:0]  fill_cnt_q;
  logic [ADDR_W-1:0] fill_base_q;
  logic [DATA_W-1:0] fill_value_q;
  logic              start_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign start_ok = bus.fill_start && below(32'(bus.fill_frame), NUM_FRAMES);

  // Write mux and next state: the host owns the port in IDLE, the fill engine in FILL.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.wr_en && below(32'(bus.wr_addr), DEPTH)) begin
          mem_we    = 1'b1;
          mem_waddr = bus.wr_addr;
          mem_wdata = bus.wr_data;
        end
        if (start_ok) state_d = FILL;
      end
      FILL: begin
        mem_we    = 1'b1;
        mem_waddr = fill_base_q + ADDR_W'(fill_cnt_q);
        mem_wdata = fill_value_q;
        if (fill_cnt_q == PIX_W'(FRAME_PIX - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      fill_cnt_q   <= '0;
      fill_base_q  <= '0;
      fill_value_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_ok) begin
        fill_base_q  <= ADDR_W'(sprite_addr(32'(bus.fill_frame), 0, 0, SPRITE_W, SPRITE_H));
        fill_value_q <= bus.fill_value;
        fill_cnt_q   <= '0;
      end else if (state_q == FILL) begin
        fill_cnt_q <= (state_d == DONE) ? '0 : fill_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the pixel array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.wr_ready  = (state_q == IDLE);
  assign bus.fill_busy = (state_q == FILL);
  assign bus.fill_done = (state_q == DONE);

  logic [ADDR_W-1:0] ch_addr  [NUM_RD];
  logic              ch_valid [NUM_RD];
  logic [DATA_W-1:0] ch_data  [NUM_RD];
  logic              ch_transp[NUM_RD];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    sprite_rd_chan #(
      .DATA_W         (DATA_W),
      .SPRITE_W       (SPRITE_W),
      .SPRITE_H       (SPRITE_H),
      .NUM_FRAMES     (NUM_FRAMES),
      .TRANSPARENT_IDX(TRANSPARENT_IDX),
      .ADDR_W         (ADDR_W),
      .FRAME_W        (FRAME_W),
      .X_W            (X_W),
      .Y_W            (Y_W)
    ) u_chan (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .req      (bus.rd_req[i]),
      .frame    (bus.rd_frame[i*FRAME_W +: FRAME_W]),
      .x        (bus.rd_x[i*X_W +: X_W]),
      .y        (bus.rd_y[i*Y_W +: Y_W]),
`ifdef SPRITE_RAM_MIRROR_EN
      .mirror   (bus.rd_mirror[i]),
`endif
      .mem_addr (ch_addr[i]),
      .mem_rdata(mem[ch_addr[i]]),
      .valid    (ch_valid[i]),
      .data     (ch_data[i]),
      .transp   (ch_transp[i])
    );
  end

  always_comb begin
    bus.rd_valid  = '0;
    bus.rd_data   = '0;
    bus.rd_transp = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_valid[i]                 = ch_valid[i];
      bus.rd_data[i*DATA_W +: DATA_W] = ch_data[i];
      bus.rd_transp[i]                = ch_transp[i];
    end
  end

endmodule
